// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer with a
// one-entry valid/ready instruction buffer towards decode.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        started;
    logic        drop;
    logic        drop_next;
    logic [31:0] pc_next;
    logic        inst_valid_next;
    logic [31:0] inst_next;
    logic [31:0] inst_pc_next;
    logic        misaligned_next;
    logic        outstanding;

    // started keeps requests off until the first clock edge after reset is released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= REQ;
            started      <= 1'b0;
            drop         <= 1'b0;
            pc_o         <= RESET_PC;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'h0;
            inst_pc_o    <= 32'h0;
            misaligned_o <= 1'b0;
        end else begin
            state        <= state_next;
            started      <= 1'b1;
            drop         <= drop_next;
            pc_o         <= pc_next;
            inst_valid_o <= inst_valid_next;
            inst_o       <= inst_next;
            inst_pc_o    <= inst_pc_next;
            misaligned_o <= misaligned_next;
        end
    end

    always_comb begin
        state_next      = state;
        drop_next       = drop;
        pc_next         = pc_o;
        inst_valid_next = inst_valid_o;
        inst_next       = inst_o;
        inst_pc_next    = inst_pc_o;
        misaligned_next = misaligned_o;

        imem_req_valid_o = started && (state == REQ) && !stall_i &&
                           (!inst_valid_o || inst_ready_i) && !redirect_valid_i;
        imem_req_addr_o  = pc_o;

        // In ERR, drop marks a request that was in flight when fetch halted
        outstanding = (state == WAIT) || ((state == ERR) && drop);

        if (inst_valid_o && inst_ready_i) begin
            inst_valid_next = 1'b0;
        end

        if (redirect_valid_i) begin
            pc_next         = redirect_pc_i;
            inst_valid_next = 1'b0;
            drop_next       = outstanding && !imem_rsp_valid_i;
            if (redirect_pc_i[1:0] != 2'b00) begin
                misaligned_next = 1'b1;
                state_next      = ERR;
            end else begin
                misaligned_next = 1'b0;
                state_next      = drop_next ? WAIT : REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_valid_o && imem_req_ready_i) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (!drop) begin
                            inst_next       = imem_rsp_data_i;
                            inst_pc_next    = pc_o;
                            inst_valid_next = 1'b1;
                            pc_next         = pc_o + 32'd4;
                        end
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end
                end
                ERR: begin
                    if (drop && imem_rsp_valid_i) begin
                        drop_next = 1'b0;
                    end
                end
                default: begin
                    state_next = REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a small memory model answers fetches and
// expected instructions are queued as responses are driven.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        misaligned_o;

    int          assertions;
    int          failures;

    entry_t      exp_q[$];
    logic [31:0] model_pc;
    logic        model_mis;
    logic        model_started;
    logic        pending;
    logic        pend_stale;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          rsp_delay;
    logic        mem_ready;
    logic        stray_rsp;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .misaligned_o     (misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr ^ 32'hDEAD_0000) + 32'h0000_0111;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        assertions++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, expected, $time);
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        model_pc      = RESET_PC;
        model_mis     = 1'b0;
        model_started = 1'b0;
        pending       = 1'b0;
        pend_stale    = 1'b0;
        pend_cnt      = 0;
    endtask

    task automatic checkReset();
        checkOutput("rst_pc", pc_o, RESET_PC);
        checkOutput("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("rst_inst", inst_o, 32'd0);
        checkOutput("rst_inst_pc", inst_pc_o, 32'd0);
        checkOutput("rst_misaligned", 32'(misaligned_o), 32'd0);
    endtask

    // One clock cycle: drive inputs just after posedge, check and update model at negedge
    task automatic applyStimulus(input logic redir, input logic [31:0] tgt,
                                 input logic stl, input logic rdy);
        logic   exp_req;
        logic   rsp;
        entry_t e;
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        stall_i          = stl;
        inst_ready_i     = rdy;
        imem_req_ready_i = mem_ready;
        rsp              = (pending && pend_cnt == 0) || stray_rsp;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = pending ? mem_word(pend_addr) : $urandom;
        @(negedge clk);
        exp_req = model_started && !pending && !model_mis && !stl && !redir &&
                  (exp_q.size() == 0 || rdy);
        checkOutput("pc", pc_o, model_pc);
        checkOutput("req_valid", 32'(imem_req_valid_o), 32'(exp_req));
        checkOutput("inst_valid", 32'(inst_valid_o), 32'(exp_q.size() != 0));
        checkOutput("misaligned", 32'(misaligned_o), 32'(model_mis));
        if (exp_q.size() != 0) begin
            checkOutput("inst", inst_o, exp_q[0].inst);
            checkOutput("inst_pc", inst_pc_o, exp_q[0].pc);
            if (rdy) void'(exp_q.pop_front());
        end
        if (exp_req) checkOutput("req_addr", imem_req_addr_o, model_pc);
        if (pending) begin
            if (rsp) begin
                if (!pend_stale && !redir) begin
                    e.pc   = pend_addr;
                    e.inst = mem_word(pend_addr);
                    exp_q.push_back(e);
                    model_pc = model_pc + 32'd4;
                end
                pending = 1'b0;
            end else if (pend_cnt != 0) begin
                pend_cnt--;
            end
        end
        if (exp_req && mem_ready) begin
            pending    = 1'b1;
            pend_stale = 1'b0;
            pend_addr  = model_pc;
            pend_cnt   = rsp_delay;
        end
        if (redir) begin
            exp_q.delete();
            model_pc  = tgt;
            model_mis = (tgt[1:0] != 2'b00);
            if (pending) pend_stale = 1'b1;
        end
        stray_rsp = 1'b0;
        @(posedge clk);
        #1;
        model_started = 1'b1;
    endtask

    task automatic runIdle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 32'h0, 1'b0, rdy);
    endtask

    task automatic waitPending(input int budget);
        for (int i = 0; i < budget && !pending; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("wait_pending", 32'(pending), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertions       = 0;
        failures         = 0;
        reset_n          = 1'b0;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        inst_ready_i     = 1'b0;
        mem_ready        = 1'b1;
        rsp_delay        = 0;
        stray_rsp        = 1'b0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkReset();
        reset_n = 1'b1;

        // Back-to-back fetches from reset: one instruction every two cycles
        $display("[TB] sequential fetch from reset");
        runIdle(10, 1'b1);

        // PC wraps past the top of the address space
        $display("[TB] wrap-around");
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        runIdle(8, 1'b1);

        // Redirect while a request is outstanding; stale response must vanish
        $display("[TB] redirect during wait");
        rsp_delay = 3;
        waitPending(10);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1);
        runIdle(12, 1'b1);

        // Decode back-pressure holds the buffer and blocks new requests
        $display("[TB] decode back-pressure");
        rsp_delay = 0;
        runIdle(3, 1'b1);
        runIdle(5, 1'b0);
        runIdle(6, 1'b1);

        // Misaligned redirect halts fetch until an aligned redirect
        $display("[TB] misaligned redirect");
        applyStimulus(1'b1, 32'h0000_0102, 1'b0, 1'b1);
        runIdle(4, 1'b1);
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b1);
        runIdle(6, 1'b1);

        // Misaligned redirect with a request still in flight
        rsp_delay = 2;
        waitPending(10);
        applyStimulus(1'b1, 32'h0000_0306, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b1);
        runIdle(10, 1'b1);

        // Randomised mix of stalls, back-pressure, memory wait states and redirects
        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            logic        redir;
            logic [31:0] tgt;
            mem_ready = ($urandom_range(0, 3) != 0);
            rsp_delay = $urandom_range(0, 3);
            redir     = ($urandom_range(0, 12) == 0);
            tgt       = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) tgt[1] = 1'b1;
            if (model_mis && $urandom_range(0, 3) == 0) begin
                redir  = 1'b1;
                tgt[1] = 1'b0;
            end
            applyStimulus(redir, tgt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end
        mem_ready = 1'b1;
        rsp_delay = 0;
        applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b1);
        runIdle(6, 1'b1);

        // Asynchronous reset mid-wait; a late response must be ignored afterwards
        $display("[TB] reset during wait");
        rsp_delay = 5;
        waitPending(10);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #2;
        reset_n          = 1'b0;
        imem_rsp_valid_i = 1'b1;
        #1;
        checkReset();
        modelReset();
        rsp_delay = 0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        stray_rsp = 1'b1;
        runIdle(10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
